ncl_wavefront_sequencer: RTL and testbench

- Clocked controller that sequences one NCL combinational stage, such as a network of th22/thmn gates behind input and output completion.
- Accepts single-rail operands on a valid/ready handshake and drives them as a dual-rail DATA wavefront.
- Waits for output completion, captures the result, then drives a NULL wavefront and waits for the stage to reset.
- Detects illegal rail codes and hangs (timeout). Used by the functional-simulation benches and the sync-to-NCL bridge.

---
 rtl/ncl_wavefront_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ncl_wavefront_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_wavefront_sequencer.sv
// Clocked sequencer for one NCL combinational stage: takes single-rail operands
// on a valid/ready handshake, drives them as a dual-rail DATA wavefront, captures
// the completed result, then returns the stage to NULL before the next operand.
//
// state  | meaning
// S_IDLE | rails NULL, waiting for an operand while ko requests data
// S_DATA | operand on the rails, waiting for DATA completion on the outputs
// S_NULL | rails NULL, waiting for NULL completion on the outputs
// S_ERR  | illegal rail code or phase timeout latched, waiting for err_clr
module ncl_wavefront_sequencer #(
  parameter int W_IN        = 2,
  parameter int W_OUT       = 1,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic [W_IN-1:0]  ncl_in_t,
  output logic [W_IN-1:0]  ncl_in_f,
  input  logic             ncl_ko,
  input  logic [W_OUT-1:0] ncl_out_t,
  input  logic [W_OUT-1:0] ncl_out_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr
);

  // Down-counter loaded on phase entry; expiry at zero lands on the cycle
  // where an up-count from phase entry would reach TIMEOUT-1.
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL, S_ERR} state_t;

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [SYNC_STAGES-1:0] ko_sync;
  logic [W_OUT-1:0] t_sync [SYNC_STAGES];
  logic [W_OUT-1:0] f_sync [SYNC_STAGES];
  logic             s_ko;
  logic [W_OUT-1:0] s_t;
  logic [W_OUT-1:0] s_f;
  logic             cmp_d, cmp_n, illegal;
  logic             cmp_d_q, cmp_n_q;
  logic             accept, consume;

  // Synchronize the asynchronous completion and output rails.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ko_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        t_sync[i] <= '0;
        f_sync[i] <= '0;
      end
    end else begin
      ko_sync   <= {ko_sync[SYNC_STAGES-2:0], ncl_ko};
      t_sync[0] <= ncl_out_t;
      f_sync[0] <= ncl_out_f;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        t_sync[i] <= t_sync[i-1];
        f_sync[i] <= f_sync[i-1];
      end
    end
  end

  assign s_ko    = ko_sync[SYNC_STAGES-1];
  assign s_t     = t_sync[SYNC_STAGES-1];
  assign s_f     = f_sync[SYNC_STAGES-1];
  assign cmp_d   = &(s_t ^ s_f);
  assign cmp_n   = ~|(s_t | s_f);
  assign illegal = |(s_t & s_f);

  // A pending result being consumed frees the sequencer in the same cycle.
  assign in_ready = (state == S_IDLE) && s_ko && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Wavefront sequencing, result capture, error latching and timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ncl_in_t  <= '0;
      ncl_in_f  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      tmr       <= '0;
      cmp_d_q   <= 1'b0;
      cmp_n_q   <= 1'b0;
    end else begin
      // Completion must hold on two consecutive samples to ride out rail skew.
      cmp_d_q <= cmp_d;
      cmp_n_q <= cmp_n;
      if (consume) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tmr <= TMR_LOAD;
          if (accept) begin
            ncl_in_t <= in_data;
            ncl_in_f <= ~in_data;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (illegal) begin
            ncl_in_t <= '0;
            ncl_in_f <= '0;
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= S_ERR;
          end else if (cmp_d && cmp_d_q && !s_ko) begin
            out_data  <= s_t;
            out_valid <= 1'b1;
            ncl_in_t  <= '0;
            ncl_in_f  <= '0;
            tmr       <= TMR_LOAD;
            state     <= S_NULL;
          end else if (tmr == '0) begin
            ncl_in_t <= '0;
            ncl_in_f <= '0;
            err      <= 1'b1;
            err_code <= 2'b10;
            state    <= S_ERR;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_NULL: begin
          if (illegal) begin
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= S_ERR;
          end else if (cmp_n && cmp_n_q && s_ko) begin
            tmr   <= TMR_LOAD;
            state <= S_IDLE;
          end else if (tmr == '0) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            state    <= S_ERR;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_ERR: begin
          if (err_clr) begin
            err      <= 1'b0;
            err_code <= 2'b00;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// Bench for ncl_wavefront_sequencer driving a modelled th22-style 2-input AND
// stage with a 3-cycle delay and selectable fault behaviour.
module tb_ncl_wavefront_sequencer;

  localparam int TMO = 12;
  localparam int N_RND = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_data = 2'b00;
  logic [1:0] ncl_in_t, ncl_in_f;
  logic       ncl_ko;
  logic [0:0] ncl_out_t, ncl_out_f;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:0] out_data;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr = 1'b0;

  ncl_wavefront_sequencer #(
    .W_IN(2), .W_OUT(1), .TIMEOUT(TMO), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ncl_in_t(ncl_in_t), .ncl_in_f(ncl_in_f),
    .ncl_ko(ncl_ko), .ncl_out_t(ncl_out_t), .ncl_out_f(ncl_out_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stage model. mode: 0 normal, 1 drive t=f=1 on DATA, 2 never complete DATA,
  // 3 hold the DATA result and never return to NULL.
  int         mode = 0;
  logic       gate_t = 1'b0, gate_f = 1'b0;
  logic       gate_nt, gate_nf;
  logic [2:0] dl_t = 3'b000, dl_f = 3'b000;

  always_comb begin
    gate_nt = gate_t;
    gate_nf = gate_f;
    if (!(mode == 3 && (gate_t || gate_f))) begin
      if ((ncl_in_t ^ ncl_in_f) == 2'b11) begin
        if (mode == 1) begin
          gate_nt = 1'b1;
          gate_nf = 1'b1;
        end else if (mode != 2) begin
          gate_nt = &ncl_in_t;
          gate_nf = ~(&ncl_in_t);
        end
      end else if ((ncl_in_t | ncl_in_f) == 2'b00) begin
        gate_nt = 1'b0;
        gate_nf = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    gate_t <= gate_nt;
    gate_f <= gate_nf;
    dl_t   <= {dl_t[1:0], gate_nt};
    dl_f   <= {dl_f[1:0], gate_nf};
  end

  assign ncl_out_t = dl_t[2];
  assign ncl_out_f = dl_f[2];
  assign ncl_ko    = ~(dl_t[2] | dl_f[2]);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 in_ready, 1 out_valid, 2 err
  task automatic wait_until(input int which, input int max_cyc, input string name,
                            output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n <= max_cyc) begin
      hit = (which == 0 && in_ready === 1'b1) || (which == 1 && out_valid === 1'b1) ||
            (which == 2 && err === 1'b1);
      if (!hit) begin
        if (n == max_cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: event not seen within %0d cycles", name, max_cyc);
        end
        step();
        n++;
      end
    end
  endtask

  task automatic send(input logic [1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [1:0] din;
    logic [1:0] exp_t;
    logic [1:0] exp_f;
    logic       exp_out;
  } vec_t;
  vec_t tbl [4];

  logic   exp_q [$];
  logic [1:0] last_op;
  int     sent, got;
  bit     acc, con;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{din: 2'b11, exp_t: 2'b11, exp_f: 2'b00, exp_out: 1'b1};
    tbl[1] = '{din: 2'b01, exp_t: 2'b01, exp_f: 2'b10, exp_out: 1'b0};
    tbl[2] = '{din: 2'b10, exp_t: 2'b10, exp_f: 2'b01, exp_out: 1'b0};
    tbl[3] = '{din: 2'b00, exp_t: 2'b00, exp_f: 2'b11, exp_out: 1'b0};

    // Reset values
    repeat (3) step();
    chk("rst_rail_t", 32'(ncl_in_t), 0);
    chk("rst_rail_f", 32'(ncl_in_f), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst = 1'b0;
    chk("post_rst_ready_low", 32'(in_ready), 0);

    // Single transactions: rails, result, latency (3 stage + 2 sync + 2 filter)
    for (int i = 0; i < 4; i++) begin
      wait_until(0, 40, "tbl_ready", cyc);
      send(tbl[i].din);
      chk("tbl_rail_t", 32'(ncl_in_t), 32'(tbl[i].exp_t));
      chk("tbl_rail_f", 32'(ncl_in_f), 32'(tbl[i].exp_f));
      chk("tbl_busy", 32'(in_ready), 0);
      wait_until(1, 40, "tbl_out_valid", cyc);
      chk("tbl_latency", cyc, 7);
      chk("tbl_out_data", 32'(out_data), 32'(tbl[i].exp_out));
      chk("tbl_rails_null", 32'({ncl_in_t, ncl_in_f}), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("tbl_consumed", 32'(out_valid), 0);
    end

    // Result held while out_ready=0; consume and accept in the same cycle
    wait_until(0, 40, "hold_ready", cyc);
    send(2'b11);
    wait_until(1, 40, "hold_out_valid", cyc);
    in_valid = 1'b1;
    in_data  = 2'b10;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_out_data", 32'(out_data), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("same_cycle_ready", 32'(in_ready), 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("same_cycle_consumed", 32'(out_valid), 0);
    chk("same_cycle_rail_t", 32'(ncl_in_t), 32'h2);
    chk("same_cycle_rail_f", 32'(ncl_in_f), 32'h1);
    wait_until(1, 40, "same_cycle_result", cyc);
    chk("same_cycle_out_data", 32'(out_data), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // err_clr outside ERR does nothing
    wait_until(0, 40, "clr_idle_ready", cyc);
    pulse_clr();
    chk("clr_idle_err", 32'(err), 0);
    chk("clr_idle_ready", 32'(in_ready), 1);

    // Illegal rail code during DATA
    mode = 1;
    send(2'b11);
    wait_until(2, 30, "illegal_err", cyc);
    chk("illegal_latency", cyc, 6);
    chk("illegal_code", 32'(err_code), 1);
    chk("illegal_rails_null", 32'({ncl_in_t, ncl_in_f}), 0);
    chk("illegal_no_result", 32'(out_valid), 0);
    in_valid = 1'b1;
    #1;
    chk("err_ignores_in_valid", 32'(in_ready), 0);
    in_valid = 1'b0;
    mode = 0;
    pulse_clr();
    chk("illegal_clr_err", 32'(err), 0);
    chk("illegal_clr_code", 32'(err_code), 0);
    wait_until(0, 40, "illegal_back_idle", cyc);

    // DATA timeout
    mode = 2;
    send(2'b01);
    wait_until(2, 40, "data_tmo", cyc);
    chk("data_tmo_cycles", cyc, TMO - 1);
    chk("data_tmo_code", 32'(err_code), 2);
    chk("data_tmo_rails", 32'({ncl_in_t, ncl_in_f}), 0);
    mode = 0;
    pulse_clr();
    wait_until(0, 40, "data_tmo_back_idle", cyc);

    // NULL timeout, counted from the edge that raised out_valid
    mode = 3;
    send(2'b11);
    wait_until(1, 40, "null_tmo_result", cyc);
    wait_until(2, 40, "null_tmo", cyc);
    chk("null_tmo_cycles", cyc, TMO - 1);
    chk("null_tmo_code", 32'(err_code), 3);
    chk("null_tmo_out_data", 32'(out_data), 1);
    mode = 0;
    pulse_clr();
    chk("null_tmo_clr_err", 32'(err), 0);
    chk("null_tmo_keeps_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_until(0, 40, "null_tmo_back_idle", cyc);

    // Asynchronous reset in the middle of DATA
    send(2'b11);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_rails", 32'({ncl_in_t, ncl_in_f}), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_err", 32'({err, err_code}), 0);
    repeat (6) step();
    rst = 1'b0;
    wait_until(0, 40, "midrst_ready", cyc);
    send(2'b11);
    wait_until(1, 40, "midrst_result", cyc);
    chk("midrst_out_data", 32'(out_data), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Randomized stream against an in-order AND-result model
    sent = 0;
    got  = 0;
    last_op = 2'b00;
    for (int c = 0; c < 3000 && got < N_RND; c++) begin
      if (!in_valid && sent < N_RND && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_data  = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (out_valid && !out_ready) chk("rnd_blocked", 32'(in_ready), 0);
      if (con) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rnd_spurious: got result %0h with nothing outstanding", out_data);
        end else begin
          chk("rnd_result", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(in_data[0] & in_data[1]);
        last_op = in_data;
        sent++;
      end
      step();
      if (acc) in_valid = 1'b0;
      if ((ncl_in_t | ncl_in_f) != 2'b00)
        chk("rnd_rails", 32'({ncl_in_t, ncl_in_f}), 32'({last_op, ~last_op}));
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("rnd_count", got, N_RND);
    chk("rnd_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
